// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Captures the winner's word, drives tx_rqst/tx_data, tracks tx_busy, then waits an optional gap.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned WORD_LENGTH   = 8,
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned GAP_CYCLES    = 0
) (
  input  logic                               clk,
  input  logic                               rstb,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ*WORD_LENGTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]                 ack,
  output logic                               tx_rqst,
  output logic [WORD_LENGTH-1:0]             tx_data,
  input  logic                               tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]         active_id,
  output logic                               arb_busy,
  output logic                               timeout_err
);

  localparam int unsigned ID_W     = $clog2(NUM_REQ);
  localparam int unsigned TMR_MAX  = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);
  localparam int unsigned TO_LAST  = START_TIMEOUT - 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  state_t                 state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [NUM_REQ-1:0]     ack_d;
  logic                   tx_rqst_d;
  logic [WORD_LENGTH-1:0] tx_data_d;
  logic [ID_W-1:0]        active_id_d;
  logic                   timeout_err_d;

  logic                   grant_valid;
  logic [ID_W-1:0]        grant_id;
  logic [WORD_LENGTH-1:0] words [NUM_REQ];

  // Unpack the flat data bus into per-requester words
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*WORD_LENGTH +: WORD_LENGTH];
    end
  end

  // Round-robin scan starting just after the last winner, with wrap
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_q) + i) % NUM_REQ;
      if (!grant_valid && req[ID_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
      ack         <= '0;
      tx_rqst     <= 1'b0;
      tx_data     <= '0;
      active_id   <= '0;
      arb_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      last_q      <= last_d;
      ack         <= ack_d;
      tx_rqst     <= tx_rqst_d;
      tx_data     <= tx_data_d;
      active_id   <= active_id_d;
      arb_busy    <= (state_d != IDLE);
      timeout_err <= timeout_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) state_d = ISSUE;
      end
      ISSUE: begin
        if (tx_busy) state_d = WAIT_DONE;
        else if (timer_q == TMR_W'(TO_LAST)) state_d = IDLE;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (timer_q == TMR_W'(GAP_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; timer restarts on every state change
  always_comb begin
    ack_d         = '0;
    tx_rqst_d     = 1'b0;
    tx_data_d     = tx_data;
    active_id_d   = active_id;
    last_d        = last_q;
    timeout_err_d = 1'b0;
    timer_d       = '0;
    if (state_d == state_q && (state_q == ISSUE || state_q == GAP)) begin
      timer_d = timer_q + TMR_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          tx_data_d   = words[grant_id];
          active_id_d = grant_id;
          last_d      = grant_id;
          tx_rqst_d   = 1'b1;
          ack_d       = NUM_REQ'(1) << grant_id;
        end
      end
      ISSUE: begin
        tx_rqst_d     = (state_d == ISSUE);
        timeout_err_d = (state_d == IDLE);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: the bench plays the transmitter's busy flag by hand.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstb;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_rqst;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  active_id;
  logic        arb_busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ(4), .WORD_LENGTH(8), .START_TIMEOUT(16), .GAP_CYCLES(5)
  ) dut (
    .clk(clk), .rstb(rstb), .req(req), .req_data(req_data), .ack(ack),
    .tx_rqst(tx_rqst), .tx_data(tx_data), .tx_busy(tx_busy),
    .active_id(active_id), .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_rqst(output int cnt);
    cnt = 0;
    while (tx_rqst !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
  endtask

  // Wait for a grant, check it, then run one frame on the fake transmitter
  task automatic serve(input int id, input logic [7:0] d, input int lat, input logic [3:0] req_after);
    int n;
    wait_rqst(n);
    chk("grant_latency", 32'(n), 32'(lat));
    chk("active_id", 32'(active_id), 32'(id));
    chk("ack_onehot", 32'(ack), 32'(1) << id);
    chk("tx_data", 32'(tx_data), 32'(d));
    chk("arb_busy_hi", 32'(arb_busy), 32'(1));
    req     = req_after;
    tx_busy = 1'b1;
    tick();
    chk("rqst_drop", 32'(tx_rqst), 32'(0));
    chk("ack_pulse", 32'(ack), 32'(0));
    tick();
    tx_busy = 1'b0;
  endtask

  initial begin
    int n;
    int hi;
    logic early_to;

    rstb     = 1'b0;
    req      = 4'b0000;
    req_data = 32'h0;
    tx_busy  = 1'b0;
    repeat (2) tick();
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_rqst", 32'(tx_rqst), 32'(0));
    chk("rst_data", 32'(tx_data), 32'(0));
    chk("rst_id", 32'(active_id), 32'(0));
    chk("rst_busy", 32'(arb_busy), 32'(0));
    chk("rst_to", 32'(timeout_err), 32'(0));
    rstb = 1'b1;
    tick();

    // Single request from requester 1
    req_data = {8'h33, 8'h44, 8'h56, 8'h11};
    req      = 4'b0010;
    serve(1, 8'h56, 1, 4'b0000);
    repeat (5) tick();
    chk("gap_busy_hold", 32'(arb_busy), 32'(1));
    tick();
    chk("idle_busy_low", 32'(arb_busy), 32'(0));

    // Full rotation from last=1 with every requester held high
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req      = 4'b1111;
    serve(2, 8'hA2, 1, 4'b1111);
    serve(3, 8'hA3, 7, 4'b1111);
    serve(0, 8'hA0, 7, 4'b1111);
    serve(1, 8'hA1, 7, 4'b1111);
    serve(2, 8'hA2, 7, 4'b1000);

    // Contention after wrap: last=3, req=1010 serves 1 then 3
    serve(3, 8'hA3, 7, 4'b1010);
    serve(1, 8'hA1, 7, 4'b1000);
    serve(3, 8'hA3, 7, 4'b0000);
    repeat (6) tick();
    chk("idle_before_to", 32'(arb_busy), 32'(0));

    // Start timeout: transmitter never goes busy
    req = 4'b0001;
    wait_rqst(n);
    chk("to_latency", 32'(n), 32'(1));
    chk("to_ack", 32'(ack), 32'(1));
    req      = 4'b0000;
    hi       = 0;
    early_to = 1'b0;
    while (tx_rqst === 1'b1 && hi < 40) begin
      if (timeout_err !== 1'b0) early_to = 1'b1;
      hi++;
      tick();
    end
    chk("to_rqst_cycles", 32'(hi), 32'(16));
    chk("to_early_pulse", 32'(early_to), 32'(0));
    chk("to_pulse", 32'(timeout_err), 32'(1));
    chk("to_idle", 32'(arb_busy), 32'(0));
    tick();
    chk("to_pulse_end", 32'(timeout_err), 32'(0));
    repeat (3) tick();
    chk("to_no_retry", 32'(tx_rqst), 32'(0));
    req = 4'b0001;
    serve(0, 8'hA0, 1, 4'b0000);
    repeat (6) tick();

    // Asynchronous reset in WAIT_DONE
    req = 4'b0010;
    wait_rqst(n);
    chk("pre_rst_id", 32'(active_id), 32'(1));
    req     = 4'b0000;
    tx_busy = 1'b1;
    tick();
    chk("pre_rst_busy", 32'(arb_busy), 32'(1));
    #2 rstb = 1'b0;
    #1;
    chk("arst_data", 32'(tx_data), 32'(0));
    chk("arst_id", 32'(active_id), 32'(0));
    chk("arst_busy", 32'(arb_busy), 32'(0));
    chk("arst_ack", 32'(ack), 32'(0));
    chk("arst_rqst", 32'(tx_rqst), 32'(0));
    chk("arst_to", 32'(timeout_err), 32'(0));
    tx_busy = 1'b0;
    req     = 4'b0101;
    tick();
    rstb = 1'b1;
    serve(0, 8'hA0, 1, 4'b0100);
    serve(2, 8'hA2, 7, 4'b0000);
    repeat (6) tick();
    chk("final_idle", 32'(arb_busy), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART_Tx_v_2 transmitter between NUM_REQ independent byte sources.
- Uses round-robin arbitration.
- Captures the winning requester's word and drives the transmitter's request/data inputs.
- Tracks the transmitter's busy flag through each frame, then enforces a programmable inter-frame gap before the next grant.
- Sits directly in front of UART_Tx_v_2; all software and DMA byte sources reach the serial line only through this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WORD_LENGTH, `WORD_LENGTH (8), data word width.
- START_TIMEOUT, 16, max clk cycles in ISSUE waiting for tx_busy to rise before abandoning the frame.
- GAP_CYCLES, 0, idle clk cycles inserted after tx_busy falls before the next grant (0 = none).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rstb  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level; held high with data stable until ack.
- req_data  in  NUM_REQ*WORD_LENGTH  per-requester word; requester i occupies bits [i*WORD_LENGTH +: WORD_LENGTH].
- ack  out  NUM_REQ  one-hot, one-cycle pulse: word captured.
- tx_rqst  out  1  to UART_Tx_RQST.
- tx_data  out  WORD_LENGTH  to Tx_DATA; registered.
- tx_busy  in  1  from UART_Tx_READY_BUSY; 1 = frame in progress.
- active_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- arb_busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse when a START_TIMEOUT expires.

Behaviour:

Reset:
- rstb low asynchronously clears: state=IDLE, ack=0, tx_rqst=0, tx_data=0, active_id=0, arb_busy=0, timeout_err=0, counters=0.
- Round-robin pointer resets to last=NUM_REQ-1, so requester 0 has first priority.

State machine:
- IDLE: if req != 0, select the first asserted req scanning from last+1 upward with wrap. On that edge:
  - latch req_data slice into tx_data;
  - set active_id and last to the winner;
  - set tx_rqst=1 and pulse ack[winner] for the next cycle only;
  - go to ISSUE.
- ISSUE: tx_rqst held 1; tx_data held.
  - tx_busy=1 → tx_rqst=0, go to WAIT_DONE.
  - Otherwise the timer increments. When the timer reaches START_TIMEOUT-1 with tx_busy still 0: tx_rqst=0, timeout_err pulses one cycle, go to IDLE. The word is dropped and not retried.
- WAIT_DONE: tx_rqst=0.
  - tx_busy=0 → GAP if GAP_CYCLES>0, else IDLE.
- GAP: count GAP_CYCLES cycles, then go to IDLE.

Timing and arbitration rules:
- Grant-to-tx_rqst latency: 1 cycle. req sampled at edge N gives tx_rqst=1 and ack=1 from edge N+1.
- Minimum spacing between grants: tx_busy-low detection + GAP_CYCLES + 1 (IDLE) cycles.
- Requests arriving while arb_busy=1 are only evaluated in IDLE. No request is lost while its req is held.
- A requester that keeps req high after its ack is treated as a new request. Round robin guarantees every other pending requester is served first.
- Simultaneous requests: strict rotation from last+1. Example with NUM_REQ=4, last=1, req=4'b1001: grant 3, then 0.
- req dropping before ack: if the drop happens before the IDLE sampling edge, nothing is granted. After capture, deassertion is ignored and the frame completes.
- tx_busy already 1 on entry to ISSUE: leave ISSUE the next cycle, as normal.
- tx_busy glitching to 0 in ISSUE has no effect. Only the rising edge matters there, and only the low level in WAIT_DONE.
- Timer width: $clog2(max(START_TIMEOUT, GAP_CYCLES)+1). The timer clears on every state entry.

Test Plan:
- Single request: NUM_REQ=4, req=4'b0010, req_data[15:8]=8'h56 → next cycle tx_rqst=1, tx_data=8'h56, ack=4'b0010 for one cycle, active_id=1. UART_Tx_OUT shows frame 0x56. arb_busy falls after tx_busy falls.
- Round robin: hold req=4'b1111 continuously with words A0..A3 → grant order 0,1,2,3,0. Exactly four acks per rotation; each UART frame completes before the next tx_rqst.
- Contention after wrap: last=3, req=4'b1010 → grant 1 first, then 3. No grant to 0 or 2.
- Timeout: tie tx_busy=0, req=4'b0001 → tx_rqst high exactly 16 cycles, timeout_err one pulse, return to IDLE, then regrant to 0 only after ack is consumed and req is re-asserted.
- Gap: GAP_CYCLES=5, two back-to-back requesters → ≥6 cycles from tx_busy falling to the next tx_rqst rising.
- Reset mid-frame: assert rstb low in WAIT_DONE → all outputs 0 immediately (asynchronous). After release with req=4'b0100, grant goes to 2 with pointer start at 0.
